// File: rtl/pc_sequencer_if.sv
// Bundle between decode/ALU/imem and the control-flow sequencer.
// The sequencer uses the slave modport; whoever drives decode and compare results uses master.
interface pc_sequencer_if #(
    parameter int CNT_W = 16
);
    logic             dec_valid;
    logic [2:0]       dec_type;
    logic             cmp_valid;
    logic             cmp_zero;
    logic             imem_ready;
    logic             halt_req;
    logic [2:0]       pc_control;
    logic             pc_en;
    logic             flush;
    logic             busy;
    logic [CNT_W-1:0] taken_cnt;

    modport master (
        output dec_valid, dec_type, cmp_valid, cmp_zero, imem_ready, halt_req,
        input  pc_control, pc_en, flush, busy, taken_cnt
    );

    modport slave (
        input  dec_valid, dec_type, cmp_valid, cmp_zero, imem_ready, halt_req,
        output pc_control, pc_en, flush, busy, taken_cnt
    );
endinterface

// File: rtl/pc_sequencer.sv
// Control-flow sequencer: turns jumps and late branch compares into pc_control/pc_en,
// stalls on imem back-pressure or halt, and flushes the wrong-path instruction on redirect.
module pc_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    pc_sequencer_if.slave     bus
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        WAIT_CMP = 2'd1,
        RESOLVE  = 2'd2,
        HALT     = 2'd3
    } state_t;

    localparam logic [2:0] TYPE_J   = 3'b001;
    localparam logic [2:0] TYPE_JR  = 3'b010;
    localparam logic [2:0] TYPE_BEQ = 3'b011;
    localparam logic [2:0] TYPE_BNE = 3'b100;

    localparam logic [2:0] SEL_SEQ    = 3'b000;
    localparam logic [2:0] SEL_JUMP   = 3'b001;
    localparam logic [2:0] SEL_REG    = 3'b010;
    localparam logic [2:0] SEL_BRANCH = 3'b011;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic             isBne_q, isBne_d;
    logic             taken_q, taken_d;
    logic             busy_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic       pcEn;
    logic [2:0] pcCtrl;
    logic       redirect;
    logic       cmpTaken;
    logic       isJump;
    logic       isBranch;

    assign isJump   = bus.dec_valid && (bus.dec_type == TYPE_J || bus.dec_type == TYPE_JR);
    assign isBranch = bus.dec_valid && (bus.dec_type == TYPE_BEQ || bus.dec_type == TYPE_BNE);
    assign cmpTaken = isBne_q ? ~bus.cmp_zero : bus.cmp_zero;

    always_comb begin
        state_d  = state_q;
        isBne_d  = isBne_q;
        taken_d  = taken_q;
        pcEn     = 1'b0;
        pcCtrl   = SEL_SEQ;
        redirect = 1'b0;

        unique case (state_q)
            RUN: begin
                if (isJump) begin
                    if (bus.imem_ready) begin
                        pcEn     = 1'b1;
                        pcCtrl   = (bus.dec_type == TYPE_J) ? SEL_JUMP : SEL_REG;
                        redirect = 1'b1;
                    end
                end else if (isBranch) begin
                    isBne_d = (bus.dec_type == TYPE_BNE);
                    state_d = WAIT_CMP;
                end else if (bus.halt_req) begin
                    state_d = HALT;
                end else begin
                    pcEn = bus.imem_ready;
                end
            end

            WAIT_CMP: begin
                if (bus.cmp_valid) begin
                    if (bus.imem_ready) begin
                        pcEn     = 1'b1;
                        pcCtrl   = cmpTaken ? SEL_BRANCH : SEL_SEQ;
                        redirect = cmpTaken;
                        state_d  = RUN;
                    end else begin
                        // Compare result is only valid for one cycle, so hold it until imem frees up.
                        taken_d = cmpTaken;
                        state_d = RESOLVE;
                    end
                end
            end

            RESOLVE: begin
                if (bus.imem_ready) begin
                    pcEn     = 1'b1;
                    pcCtrl   = taken_q ? SEL_BRANCH : SEL_SEQ;
                    redirect = taken_q;
                    state_d  = RUN;
                end
            end

            HALT: begin
                if (!bus.halt_req) begin
                    state_d = RUN;
                end
            end

            default: state_d = RUN;
        endcase

        cnt_d = cnt_q;
        if (redirect && cnt_q != '1) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            isBne_q <= 1'b0;
            taken_q <= 1'b0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            isBne_q <= isBne_d;
            taken_q <= taken_d;
            busy_q  <= (state_d != RUN);
            cnt_q   <= cnt_d;
        end
    end

    // Mealy outputs are forced quiet while reset is held so the PC never moves during reset.
    assign bus.pc_en      = rst_n & pcEn;
    assign bus.pc_control = rst_n ? pcCtrl : SEL_SEQ;
    assign bus.flush      = rst_n & redirect;
    assign bus.busy       = busy_q;
    assign bus.taken_cnt  = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: hand-computed expectations per cycle, plus a
// narrow-counter instance to exercise saturation.
module tb_pc_sequencer;

    localparam logic [2:0] T_OTHER = 3'b000;
    localparam logic [2:0] T_J     = 3'b001;
    localparam logic [2:0] T_JR    = 3'b010;
    localparam logic [2:0] T_BEQ   = 3'b011;
    localparam logic [2:0] T_BNE   = 3'b100;
    localparam logic [2:0] T_RSVD  = 3'b101;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    int   expCnt;

    pc_sequencer_if #(.CNT_W(16)) mIf ();
    pc_sequencer_if #(.CNT_W(2))  sIf ();

    pc_sequencer #(.CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (mIf)
    );

    pc_sequencer #(.CNT_W(2)) dutSat (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sIf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic checkMealy(input string tag, input logic en, input logic [2:0] ctrl, input logic fl);
        checkOutput({tag, ".pc_en"}, 32'(mIf.pc_en), 32'(en));
        checkOutput({tag, ".pc_control"}, 32'(mIf.pc_control), 32'(ctrl));
        checkOutput({tag, ".flush"}, 32'(mIf.flush), 32'(fl));
    endtask

    // Advance one clock, then drive this cycle's inputs; checks follow 1ns later.
    task automatic applyStimulus(input logic rstN, input logic dv, input logic [2:0] ty,
                                 input logic cv, input logic cz, input logic rdy, input logic halt);
        @(posedge clk);
        #2;
        rst_n          = rstN;
        mIf.dec_valid  = dv;
        mIf.dec_type   = ty;
        mIf.cmp_valid  = cv;
        mIf.cmp_zero   = cz;
        mIf.imem_ready = rdy;
        mIf.halt_req   = halt;
        #1;
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        expCnt = 0;

        sIf.dec_valid  = 1'b0;
        sIf.dec_type   = T_OTHER;
        sIf.cmp_valid  = 1'b0;
        sIf.cmp_zero   = 1'b0;
        sIf.imem_ready = 1'b1;
        sIf.halt_req   = 1'b0;

        rst_n          = 1'b0;
        mIf.dec_valid  = 1'b1;
        mIf.dec_type   = 3'b111;
        mIf.cmp_valid  = 1'b1;
        mIf.cmp_zero   = 1'b1;
        mIf.imem_ready = 1'b1;
        mIf.halt_req   = 1'b1;
        #3;
        checkMealy("rst0", 1'b0, 3'b000, 1'b0);
        checkOutput("rst0.busy", 32'(mIf.busy), 32'd0);
        checkOutput("rst0.cnt", 32'(mIf.taken_cnt), 32'd0);

        applyStimulus(1'b0, 1'b1, T_J, 1'b1, 1'b1, 1'b1, 1'b1);
        checkMealy("rst1", 1'b0, 3'b000, 1'b0);
        checkOutput("rst1.busy", 32'(mIf.busy), 32'd0);
        checkOutput("rst1.cnt", 32'(mIf.taken_cnt), 32'd0);

        applyStimulus(1'b1, 1'b0, T_OTHER, 1'b0, 1'b0, 1'b1, 1'b0);
        checkMealy("release", 1'b1, 3'b000, 1'b0);
        checkOutput("release.busy", 32'(mIf.busy), 32'd0);

        applyStimulus(1'b1, 1'b1, T_J, 1'b0, 1'b0, 1'b1, 1'b0);
        checkMealy("j", 1'b1, 3'b001, 1'b1);
        checkOutput("j.cnt_before", 32'(mIf.taken_cnt), 32'd0);
        expCnt = 1;
        applyStimulus(1'b1, 1'b0, T_OTHER, 1'b0, 1'b0, 1'b1, 1'b0);
        checkMealy("j.after", 1'b1, 3'b000, 1'b0);
        checkOutput("j.cnt_after", 32'(mIf.taken_cnt), 32'(expCnt));

        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1, T_JR, 1'b0, 1'b0, 1'b0, 1'b0);
            checkMealy("jr.stall", 1'b0, 3'b000, 1'b0);
        end
        applyStimulus(1'b1, 1'b1, T_JR, 1'b0, 1'b0, 1'b1, 1'b0);
        checkMealy("jr.go", 1'b1, 3'b010, 1'b1);
        checkOutput("jr.cnt_before", 32'(mIf.taken_cnt), 32'(expCnt));
        expCnt = 2;
        applyStimulus(1'b1, 1'b1, T_RSVD, 1'b0, 1'b0, 1'b1, 1'b0);
        checkMealy("other101", 1'b1, 3'b000, 1'b0);
        checkOutput("jr.cnt_after", 32'(mIf.taken_cnt), 32'(expCnt));

        applyStimulus(1'b1, 1'b1, T_BEQ, 1'b0, 1'b0, 1'b1, 1'b0);
        checkMealy("beq.accept", 1'b0, 3'b000, 1'b0);
        checkOutput("beq.accept.busy", 32'(mIf.busy), 32'd0);
        applyStimulus(1'b1, 1'b1, T_BEQ, 1'b0, 1'b0, 1'b1, 1'b1);
        checkMealy("beq.wait", 1'b0, 3'b000, 1'b0);
        checkOutput("beq.wait.busy", 32'(mIf.busy), 32'd1);
        applyStimulus(1'b1, 1'b1, T_BEQ, 1'b1, 1'b1, 1'b1, 1'b0);
        checkMealy("beq.taken", 1'b1, 3'b011, 1'b1);
        expCnt = 3;
        applyStimulus(1'b1, 1'b0, T_OTHER, 1'b0, 1'b0, 1'b1, 1'b0);
        checkMealy("beq.after", 1'b1, 3'b000, 1'b0);
        checkOutput("beq.cnt", 32'(mIf.taken_cnt), 32'(expCnt));
        checkOutput("beq.after.busy", 32'(mIf.busy), 32'd0);

        applyStimulus(1'b1, 1'b1, T_BNE, 1'b0, 1'b0, 1'b1, 1'b0);
        checkMealy("bne.accept", 1'b0, 3'b000, 1'b0);
        applyStimulus(1'b1, 1'b1, T_BNE, 1'b1, 1'b1, 1'b1, 1'b0);
        checkMealy("bne.nottaken", 1'b1, 3'b000, 1'b0);
        applyStimulus(1'b1, 1'b0, T_OTHER, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("bne.cnt", 32'(mIf.taken_cnt), 32'(expCnt));

        applyStimulus(1'b1, 1'b1, T_BEQ, 1'b0, 1'b0, 1'b1, 1'b0);
        checkMealy("res.accept", 1'b0, 3'b000, 1'b0);
        applyStimulus(1'b1, 1'b1, T_BEQ, 1'b1, 1'b1, 1'b0, 1'b0);
        checkMealy("res.cmp", 1'b0, 3'b000, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1, T_BEQ, 1'b1, 1'b0, 1'b0, 1'b0);
            checkMealy("res.hold", 1'b0, 3'b000, 1'b0);
            checkOutput("res.hold.busy", 32'(mIf.busy), 32'd1);
        end
        applyStimulus(1'b1, 1'b1, T_BEQ, 1'b1, 1'b0, 1'b1, 1'b0);
        checkMealy("res.issue", 1'b1, 3'b011, 1'b1);
        expCnt = 4;
        applyStimulus(1'b1, 1'b0, T_OTHER, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("res.cnt", 32'(mIf.taken_cnt), 32'(expCnt));

        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b0, T_OTHER, 1'b0, 1'b0, 1'b1, 1'b1);
            checkMealy("halt", 1'b0, 3'b000, 1'b0);
            if (i > 0) checkOutput("halt.busy", 32'(mIf.busy), 32'd1);
        end
        applyStimulus(1'b1, 1'b0, T_OTHER, 1'b0, 1'b0, 1'b1, 1'b0);
        checkMealy("halt.leave", 1'b0, 3'b000, 1'b0);
        applyStimulus(1'b1, 1'b0, T_OTHER, 1'b0, 1'b0, 1'b1, 1'b0);
        checkMealy("halt.resume", 1'b1, 3'b000, 1'b0);
        checkOutput("halt.resume.busy", 32'(mIf.busy), 32'd0);

        applyStimulus(1'b1, 1'b1, T_J, 1'b0, 1'b0, 1'b1, 1'b1);
        checkMealy("jhalt.jump", 1'b1, 3'b001, 1'b1);
        expCnt = 5;
        applyStimulus(1'b1, 1'b0, T_OTHER, 1'b0, 1'b0, 1'b1, 1'b1);
        checkMealy("jhalt.stop", 1'b0, 3'b000, 1'b0);
        checkOutput("jhalt.cnt", 32'(mIf.taken_cnt), 32'(expCnt));
        applyStimulus(1'b1, 1'b0, T_OTHER, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("jhalt.busy", 32'(mIf.busy), 32'd1);
        applyStimulus(1'b1, 1'b0, T_OTHER, 1'b0, 1'b0, 1'b1, 1'b0);
        checkMealy("jhalt.resume", 1'b1, 3'b000, 1'b0);

        applyStimulus(1'b1, 1'b1, T_BEQ, 1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, T_BEQ, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("mid.busy_pre", 32'(mIf.busy), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("mid.busy_rst", 32'(mIf.busy), 32'd0);
        checkMealy("mid.rst", 1'b0, 3'b000, 1'b0);
        expCnt = 0;
        applyStimulus(1'b1, 1'b0, T_OTHER, 1'b1, 1'b1, 1'b1, 1'b0);
        checkMealy("mid.release", 1'b1, 3'b000, 1'b0);
        checkOutput("mid.cnt", 32'(mIf.taken_cnt), 32'(expCnt));
        checkOutput("mid.busy", 32'(mIf.busy), 32'd0);

        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #2;
            sIf.dec_valid = 1'b1;
            sIf.dec_type  = T_J;
            #1;
            checkOutput("sat.cnt", 32'(sIf.taken_cnt), (i < 3) ? i : 3);
            checkOutput("sat.flush", 32'(sIf.flush), 32'd1);
        end
        @(posedge clk);
        #2;
        sIf.dec_valid = 1'b0;
        #1;
        checkOutput("sat.final", 32'(sIf.taken_cnt), 32'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
